// File: rtl/sp_ram_bist_pkg.sv
// Shared types and the March C- element table for the single-port RAM BIST engine.
package sp_ram_bist_pkg;

  localparam int NUM_ELEMS = 6;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RW_RD, S_RW_WR, S_DRAIN, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M0 = 3'd0, M1 = 3'd1, M2 = 3'd2, M3 = 3'd3, M4 = 3'd4, M5 = 3'd5
  } elem_t;

  typedef struct packed {
    logic down;
    logic has_read;
    logic has_write;
    logic rd_inv;
    logic wr_inv;
  } march_op_t;

  // Columns: down, has_read, has_write, rd_inv, wr_inv
  localparam march_op_t MARCH_TBL [NUM_ELEMS] = '{
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // M0 up   w(P)
    '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},  // M1 up   r(P)  w(~P)
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // M2 up   r(~P) w(P)
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},  // M3 down r(P)  w(~P)
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // M4 down r(~P) w(P)
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}   // M5 down r(P)
  };

  function automatic elem_t next_elem(input elem_t e);
    return elem_t'(e + 3'd1);
  endfunction

endpackage

// File: rtl/sp_ram_bist_addr_gen.sv
// Loadable up/down word-address counter with first/last flags for the current direction.
module sp_ram_bist_addr_gen
  import sp_ram_bist_pkg::*;
#(
  parameter int NUM_WORDS  = 8192,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? MAX_ADDR : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign first = down ? (addr == MAX_ADDR) : (addr == '0);
  assign last  = down ? (addr == '0)       : (addr == MAX_ADDR);

endmodule

// File: rtl/sp_ram_march_bist.sv
// March C- BIST engine driving a single-port RAM wrapper port.
// Optional saturating miscompare counter (err_cnt_o) when BIST_ERR_CNT_EN is defined.
module sp_ram_march_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int          NUM_WORDS  = 8192,
  parameter int          ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter logic [31:0] PATTERN    = 32'h5555_5555
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic                  ram_bypass_en_o,
  input  logic [31:0]           ram_rdata_i
`ifdef BIST_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
`endif
);

  state_t                  state_q, state_d;
  elem_t                   elem_q, elem_d;
  march_op_t               cur_op;
  logic                    ag_load, ag_step, ag_first, ag_last, start_run;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    rd_issue, wr_issue, miscompare;
  logic                    cmp_vld_q, fail_seen_q, pass_q;
  logic [31:0]             cmp_exp_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, fail_addr_q;
  elem_t                   cmp_elem_q, fail_elem_q;

  assign cur_op = MARCH_TBL[elem_q];

  sp_ram_bist_addr_gen #(
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_i     (rst_i),
    .load      (ag_load),
    .load_down (MARCH_TBL[elem_d].down),
    .step      (ag_step),
    .down      (cur_op.down),
    .addr      (addr),
    .first     (ag_first),
    .last      (ag_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    start_run = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_WR;
        elem_d    = M0;
        ag_load   = !ag_first;
        start_run = 1'b1;
      end
      S_WR: if (ag_last) begin
        state_d = S_RW_RD;
        elem_d  = M1;
        ag_load = 1'b1;
      end else begin
        ag_step = 1'b1;
      end
      S_RW_RD: state_d = S_RW_WR;
      S_RW_WR: if (!ag_last) begin
        state_d = S_RW_RD;
        ag_step = 1'b1;
      end else begin
        elem_d  = next_elem(elem_q);
        ag_load = 1'b1;
        state_d = MARCH_TBL[elem_d].has_write ? S_RW_RD : S_RD;
      end
      S_RD: if (ag_last) state_d = S_DRAIN;
            else         ag_step = 1'b1;
      S_DRAIN: state_d = S_DONE;
      // Park the element on M0 so the idle address counter direction is upward.
      S_DONE: begin
        state_d = S_IDLE;
        elem_d  = M0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_issue   = (state_q == S_RD || state_q == S_RW_RD) && cur_op.has_read;
  assign wr_issue   = (state_q == S_WR || state_q == S_RW_WR) && cur_op.has_write;
  assign miscompare = cmp_vld_q && (ram_rdata_i != cmp_exp_q);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      elem_q      <= M0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= M0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= M0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      cmp_vld_q <= rd_issue;
      if (rd_issue) begin
        cmp_exp_q  <= cur_op.rd_inv ? ~PATTERN : PATTERN;
        cmp_addr_q <= addr;
        cmp_elem_q <= elem_q;
      end
      if (start_run) begin
        fail_seen_q <= 1'b0;
        pass_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= M0;
      end else if (miscompare && !fail_seen_q) begin
        fail_seen_q <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_elem_q <= cmp_elem_q;
      end
      // The last read's compare lands in DRAIN, so the verdict is final here.
      if (state_q == S_DRAIN) pass_q <= !fail_seen_q && !miscompare;
    end
  end

`ifdef BIST_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i || start_run)                err_cnt_q <= '0;
    else if (miscompare && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign busy_o          = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_RW_RD) ||
                           (state_q == S_RW_WR) || (state_q == S_DRAIN);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = pass_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_elem_o     = fail_elem_q;
  assign ram_en_o        = rd_issue || wr_issue;
  assign ram_we_o        = wr_issue;
  assign ram_addr_o      = addr;
  assign ram_wdata_o     = wr_issue ? (cur_op.wr_inv ? ~PATTERN : PATTERN) : 32'h0;
  assign ram_be_o        = 4'hF;
  assign ram_bypass_en_o = 1'b0;

endmodule
